// File: rtl/uart_tx_engine.sv
// UART transmitter with a small TX FIFO and a programmable bit divider; 8N1 frames by default.
// Define UART_TX_PARITY_EN to add a parity bit (parity_odd input) after the data bits.
module uart_tx_engine #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clk_divider_valid,
  input  logic [DIV_W-1:0] clk_divider,
  input  logic             tx_data_valid,
  input  logic [7:0]       tx_data,
`ifdef UART_TX_PARITY_EN
  input  logic             parity_odd,
`endif
  output logic             tx_ready,
  output logic             sout,
  output logic             sck_rising_edge,
  output logic             transmitter_busy
);

  localparam int   PTR_W         = $clog2(FIFO_DEPTH);
  localparam int   CNT_W         = PTR_W + 1;
  localparam logic LAST_STOP_IDX = (STOP_BITS == 2);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t             state;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic [DIV_W-1:0]   div_reg;
  logic [DIV_W-1:0]   div_cur;
  logic [DIV_W-1:0]   bit_cnt;
  logic [DIV_W-1:0]   div_clamped;
  logic [7:0]         shreg;
  logic [2:0]         bit_idx;
  logic               stop_idx;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               bit_end;
  logic               last_stop;
  logic               frame_active_nxt;
`ifdef UART_TX_PARITY_EN
  logic               par_bit;
`endif

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    fifo_empty  = (count == '0);
    push        = tx_data_valid && tx_ready;
    bit_end     = (bit_cnt == div_cur - DIV_W'(1));
    last_stop   = (state == S_STOP) && bit_end && (stop_idx == LAST_STOP_IDX);
    // A new frame starts from IDLE or directly out of the final stop cycle (back-to-back).
    pop         = en && !fifo_empty && ((state == S_IDLE) || last_stop);
    div_clamped = (clk_divider < DIV_W'(2)) ? DIV_W'(2) : clk_divider;
    frame_active_nxt = pop || (en && (state != S_IDLE) && !last_stop);
    count_nxt   = count;
    if (push && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // NOTE: FIFO storage is deliberately not reset; entries are only read behind a non-zero count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every block samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_ready <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;
      // Registered from the next count, so a full FIFO refuses a push even in a cycle that pops.
      tx_ready <= (count_nxt != CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      sout             <= 1'b1;
      sck_rising_edge  <= 1'b0;
      transmitter_busy <= 1'b0;
      div_reg          <= DIV_W'(2);
      div_cur          <= DIV_W'(2);
      bit_cnt          <= '0;
      bit_idx          <= '0;
      stop_idx         <= 1'b0;
      shreg            <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit          <= 1'b0;
`endif
    end else begin
      sck_rising_edge  <= 1'b0;
      transmitter_busy <= frame_active_nxt || (count_nxt != '0);
      if (clk_divider_valid) begin
        div_reg <= div_clamped;
      end

      if (pop) begin
        // The divider is shadowed here so mid-frame writes only affect the next frame.
        state           <= S_START;
        sout            <= 1'b0;
        sck_rising_edge <= 1'b1;
        bit_cnt         <= '0;
        shreg           <= mem[rd_ptr];
        div_cur         <= div_reg;
`ifdef UART_TX_PARITY_EN
        par_bit         <= (^mem[rd_ptr]) ^ parity_odd;
`endif
      end else if (!en) begin
        state <= S_IDLE;
        sout  <= 1'b1;
      end else if (state != S_IDLE) begin
        if (!bit_end) begin
          bit_cnt <= bit_cnt + DIV_W'(1);
        end else begin
          bit_cnt         <= '0;
          sck_rising_edge <= 1'b1;
          case (state)
            S_START: begin
              state   <= S_DATA;
              sout    <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= '0;
            end
            S_DATA: begin
              if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                state    <= S_PARITY;
                sout     <= par_bit;
`else
                state    <= S_STOP;
                sout     <= 1'b1;
                stop_idx <= 1'b0;
`endif
              end else begin
                sout    <= shreg[0];
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 3'd1;
              end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
              state    <= S_STOP;
              sout     <= 1'b1;
              stop_idx <= 1'b0;
            end
`endif
            S_STOP: begin
              if (stop_idx == LAST_STOP_IDX) begin
                state           <= S_IDLE;
                sout            <= 1'b1;
                sck_rising_edge <= 1'b0;
              end else begin
                stop_idx <= 1'b1;
              end
            end
            default: begin
              state <= S_IDLE;
              sout  <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: frame shape, FIFO fill/drop, divider clamp/shadow, abort, 2 stop bits.
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, div_valid, tx_valid;
  logic [15:0] div_val;
  logic [7:0]  tx_data;
  logic        tx_ready, sout, sck, busy;
  logic        en2, div_valid2, tx_valid2;
  logic [15:0] div_val2;
  logic [7:0]  tx_data2;
  logic        tx_ready2, sout2, sck2, busy2;
`ifdef UART_TX_PARITY_EN
  logic        parity_odd;
  logic        parity_odd2;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_engine u_dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .clk_divider_valid(div_valid), .clk_divider(div_val),
    .tx_data_valid(tx_valid), .tx_data(tx_data),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .tx_ready(tx_ready), .sout(sout), .sck_rising_edge(sck), .transmitter_busy(busy)
  );

  uart_tx_engine #(.STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2),
    .clk_divider_valid(div_valid2), .clk_divider(div_val2),
    .tx_data_valid(tx_valid2), .tx_data(tx_data2),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd2),
`endif
    .tx_ready(tx_ready2), .sout(sout2), .sck_rising_edge(sck2), .transmitter_busy(busy2)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_div(input logic [15:0] v);
    div_val = v; div_valid = 1'b1; tick(); div_valid = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    tx_data = b; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
  endtask

  // Waits for the start bit, then checks every cycle of the frame (sout level and bit-start pulse).
  task automatic check_frame(input string tag, input logic [7:0] b, input int div,
                             input int exp_gap, input logic has_par, input logic pbit);
    int   gap = 0;
    int   nbits;
    logic exp_bit;
    while (sout !== 1'b0 && gap < 400) begin
      gap++;
      tick();
    end
    check({tag, " start_seen"}, sout, 1'b0);
    if (exp_gap >= 0) check({tag, " start_gap"}, gap, exp_gap);
    nbits = has_par ? 11 : 10;
    for (int k = 0; k < nbits; k++) begin
      if (k == 0)                 exp_bit = 1'b0;
      else if (k <= 8)            exp_bit = b[k-1];
      else if (has_par && k == 9) exp_bit = pbit;
      else                        exp_bit = 1'b1;
      for (int c = 0; c < div; c++) begin
        check($sformatf("%s bit%0d cyc%0d sout", tag, k, c), sout, exp_bit);
        check($sformatf("%s bit%0d cyc%0d sck", tag, k, c), sck, (c == 0));
        tick();
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows, highs, pulses;
    rst_n = 1'b0;
    en = 1'b0; div_valid = 1'b0; div_val = '0; tx_valid = 1'b0; tx_data = '0;
    en2 = 1'b0; div_valid2 = 1'b0; div_val2 = '0; tx_valid2 = 1'b0; tx_data2 = '0;
`ifdef UART_TX_PARITY_EN
    parity_odd = 1'b0; parity_odd2 = 1'b0;
`endif
    tick(); tick();
    check("reset sout", sout, 1'b1);
    check("reset tx_ready", tx_ready, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset sck", sck, 1'b0);
    check("reset sout2", sout2, 1'b1);
    rst_n = 1'b1;
    tick();

    // Test 1: div=4, single byte 0x55
    en = 1'b1;
    set_div(16'd4);
    write_byte(8'h55);
    check("t1 busy after write", busy, 1'b1);
    check("t1 sout still idle", sout, 1'b1);
    check_frame("t1 0x55", 8'h55, 4, 1, 1'b0, 1'b0);
    check("t1 busy end", busy, 1'b0);

    // Test 2: fill the FIFO with transmitter disabled, 5th byte dropped, then 4 back-to-back frames
    en = 1'b0;
    set_div(16'd8);
    for (int i = 0; i < 5; i++) begin
      tx_data = 8'h41 + 8'(i); tx_valid = 1'b1;
      tick();
      if (i == 3) check("t2 tx_ready full", tx_ready, 1'b0);
    end
    tx_valid = 1'b0;
    check("t2 busy queued", busy, 1'b1);
    check("t2 sout idle en=0", sout, 1'b1);
    en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check_frame($sformatf("t2 byte%0d", j), 8'h41 + 8'(j), 8, (j == 0) ? 1 : 0, 1'b0, 1'b0);
    end
    check("t2 busy end", busy, 1'b0);
    check("t2 tx_ready end", tx_ready, 1'b1);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (sout == 1'b0) lows++;
      tick();
    end
    check("t2 dropped byte not sent", lows, 0);

    // Test 3: divider 1 clamps to 2; mid-frame write of 6 applies to next frame only
    set_div(16'd1);
    write_byte(8'hA5);
    write_byte(8'h3C);
    fork
      begin
        check_frame("t3 0xA5", 8'hA5, 2, -1, 1'b0, 1'b0);
        check_frame("t3 0x3C", 8'h3C, 6, 0, 1'b0, 1'b0);
      end
      begin
        repeat (6) tick();
        set_div(16'd6);
      end
    join
    check("t3 busy end", busy, 1'b0);

    // Test 4: abort during data bit 3 of 0xFF with 0x12 queued
    write_byte(8'hFF);
    write_byte(8'h12);
    lows = 0;
    while (sout !== 1'b0 && lows < 400) begin
      lows++;
      tick();
    end
    check("t4 start seen", sout, 1'b0);
    repeat (26) tick();
    check("t4 in frame busy", busy, 1'b1);
    en = 1'b0;
    tick();
    check("t4 abort sout", sout, 1'b1);
    check("t4 abort busy", busy, 1'b1);
    check("t4 abort sck", sck, 1'b0);
    pulses = 0; lows = 0;
    for (int i = 0; i < 30; i++) begin
      if (sck == 1'b1) pulses++;
      if (sout == 1'b0) lows++;
      tick();
    end
    check("t4 sck stopped", pulses, 0);
    check("t4 sout held high", lows, 0);
    check("t4 busy kept", busy, 1'b1);
    en = 1'b1;
    check_frame("t4 0x12", 8'h12, 6, 1, 1'b0, 1'b0);
    check("t4 busy end", busy, 1'b0);

`ifdef UART_TX_PARITY_EN
    // Test 6: parity bit, even then odd, 11-bit frame
    set_div(16'd4);
    parity_odd = 1'b0;
    write_byte(8'h07);
    check_frame("t6 even", 8'h07, 4, 1, 1'b1, 1'b1);
    check("t6 even busy end", busy, 1'b0);
    parity_odd = 1'b1;
    write_byte(8'h07);
    check_frame("t6 odd", 8'h07, 4, 1, 1'b1, 1'b0);
    check("t6 odd busy end", busy, 1'b0);
    parity_odd = 1'b0;
`endif

    // Test 5: STOP_BITS=2 instance; first a frame at the reset divider (2), then div=5
    en2 = 1'b1;
    tx_data2 = 8'h00; tx_valid2 = 1'b1; tick(); tx_valid2 = 1'b0;
    lows = 0;
    while (sout2 !== 1'b0 && lows < 400) begin
      lows++;
      tick();
    end
    check("t5 default div start", sout2, 1'b0);
    lows = 0;
    while (sout2 === 1'b0 && lows < 400) begin
      lows++;
      tick();
    end
    check("t5 default div low run", lows, 18);
    repeat (10) tick();
    check("t5 idle busy2", busy2, 1'b0);
    div_val2 = 16'd5; div_valid2 = 1'b1; tick(); div_valid2 = 1'b0;
    tx_data2 = 8'h00; tx_valid2 = 1'b1; tick(); tick(); tx_valid2 = 1'b0;
    lows = 0;
    while (sout2 !== 1'b0 && lows < 400) begin
      lows++;
      tick();
    end
    check("t5 start seen", sout2, 1'b0);
    lows = 0;
    while (sout2 === 1'b0 && lows < 400) begin
      lows++;
      tick();
    end
    check("t5 low run frame1", lows, 45);
    highs = 0;
    while (sout2 === 1'b1 && highs < 400) begin
      highs++;
      tick();
    end
    check("t5 stop high run", highs, 10);
    lows = 0;
    while (sout2 === 1'b0 && lows < 400) begin
      lows++;
      tick();
    end
    check("t5 low run frame2", lows, 45);
    repeat (12) tick();
    check("t5 busy2 end", busy2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- UART transmitter for the SoC peripheral side: serialises bytes from the bus onto `sout` in 8N1 format by default (LSB first).
- Buffers writes in a small FIFO.
- Generates its own bit-rate tick from a programmable divider.
- It is the transmit half of the same serial link that the SoC-level bench UART interface samples and decodes.

Parameters:
- FIFO_DEPTH, 4: TX FIFO entries; power of two, minimum 2.
- DIV_W, 16: width of `clk_divider`.
- STOP_BITS, 1: number of stop bits; legal values are 1 or 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  transmitter enable
- clk_divider_valid  input  1  one-cycle strobe; load `clk_divider`
- clk_divider  input  DIV_W  clocks per serial bit
- tx_data_valid  input  1  write strobe; byte accepted when `tx_ready`=1
- tx_data  input  8  byte to transmit
- tx_ready  output  1  FIFO not full
- sout  output  1  serial output; idle high
- sck_rising_edge  output  1  one-cycle pulse at the start of every bit period
- transmitter_busy  output  1  frame in progress or FIFO non-empty

Behaviour:
- Clock and reset
  - Single clock domain `clk`.
  - Reset is asynchronous and active-low on `rst_n`.
  - Reset values: `sout`=1, `tx_ready`=1, `transmitter_busy`=0, `sck_rising_edge`=0.
  - Reset values of internal state: FIFO empty, divider register=2, state IDLE.
- Divider register
  - Loaded on `clk_divider_valid`.
  - Loaded values below 2 are clamped to 2.
  - A shadow copy is taken at each frame start; divider writes during a frame take effect on the next frame only.
- FIFO
  - Write when `tx_data_valid` && `tx_ready`.
  - Writes while full are dropped; FIFO contents are unchanged.
  - Simultaneous push and pop is legal when full: the pop frees an entry, but `tx_ready` is computed from the registered count and is 0 that cycle, so the push is dropped.
  - `tx_ready` = !full, registered.
  - Pointers wrap modulo FIFO_DEPTH.
- Bit timing
  - Bit counter runs 0..div-1.
  - `sck_rising_edge` pulses when the counter is 0.
  - Each bit holds `sout` for exactly div clocks.
- State machine: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: when `en`=1 and FIFO non-empty, pop the head into the shift register and go to START.
    - `sout` falls on the cycle after the pop: 1-cycle latency from the pop condition.
    - Write-to-`sout`-low latency from an empty FIFO is 2 clocks.
  - START: `sout`=0 for div clocks, then go to DATA.
  - DATA: shift out 8 bits, LSB first, div clocks each.
    - After bit 7, go to PARITY if the macro is enabled, else STOP.
  - STOP: `sout`=1 for STOP_BITS×div clocks.
    - Then return to IDLE.
    - If the FIFO is non-empty and `en`=1, the next START follows back-to-back with no extra idle cycle.
- `transmitter_busy` = (state != IDLE) || FIFO non-empty.
- `en` deasserted mid-frame: the frame aborts at the next clock.
  - `sout`=1, state=IDLE.
  - The current byte is discarded; FIFO contents are kept.
  - `sck_rising_edge` stops.
- `en`=0 in IDLE: FIFO still accepts writes; no frame starts.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Enabled:
  - Adds input `parity_odd` (1 bit), sampled at frame start.
  - PARITY state follows bit 7 for div clocks.
  - Parity bit = XOR of the data byte (even parity), inverted when `parity_odd`=1.
  - Frame length becomes 11 bits with STOP_BITS=1.
- Disabled: no `parity_odd` port and no PARITY state; frame is 10 bits with STOP_BITS=1.

Test Plan:
1. Reset, then div=4, `en`=1, write 0x55.
   - `sout` low 2 clocks after the write.
   - Pattern 0,1,0,1,0,1,0,1,0,1, each bit held 4 clocks.
   - `transmitter_busy` drops after 40 clocks of frame.
2. Write 0x41, 0x42, 0x43, 0x44, 0x45 in consecutive cycles with div=8.
   - `tx_ready`=0 after the 4th byte is accepted; 0x45 is dropped.
   - Four frames are sent back-to-back with no idle gap.
   - Decoded bytes are 0x41, 0x42, 0x43, 0x44.
3. Write `clk_divider`=1, then send 0xA5.
   - Bit period is 2 clocks (clamped).
   - Write `clk_divider`=6 mid-frame: the current frame stays at 2 clocks per bit; the next frame uses 6.
4. Deassert `en` during DATA bit 3 of 0xFF, with 0x12 queued.
   - `sout`=1 next clock; busy stays 1 because the FIFO is non-empty.
   - Re-assert `en`: 0x12 is sent intact.
5. STOP_BITS=2, div=5, send 0x00.
   - `sout` low 45 clocks (start plus 8 data bits), then high 10 clocks before the next start.
6. UART_TX_PARITY_EN defined.
   - 0x07 with `parity_odd`=0: parity bit=1.
   - 0x07 with `parity_odd`=1: parity bit=0.
   - Frame is 11 bits.
